fetch_stall_ctrl: RTL and testbench

Responder side of the load-use hazard interface in the 5-stage MIPS pipeline. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It acts on the hazard unit's `pcwrite`/`hazardflag` by freezing fetch and injecting bubbles, and on EX-stage branch resolution by flushing. It also tracks stall duration and flags protocol violations on the stall interface.

---
 rtl/fetch_stall_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_stall_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side load-use responder: PC, IF/ID and ID/EX control, with freeze, bubble and flush.
// Optional FETCH_STALL_PERF_EN macro compiles in the stall/flush performance counters.
module fetch_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter int          MAX_STALL = 4,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcwrite,
  input  logic              hazardflag,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pcplus4,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              stall_timeout,
  output logic              protocol_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  // Handshake: hazard unit drives pcwrite=0 together with hazardflag=1 to
  // request a hold; any equal pair is a protocol violation but still stalls.
  localparam int LEN_W = $clog2(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] stall_len, stall_len_next;
  logic             stall, mismatch, timeout_hit;
  logic [31:0]      pc_plus4;

  assign stall    = ~pcwrite | hazardflag;
  assign mismatch = ~(pcwrite ^ hazardflag);
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_next     = state;
    stall_len_next = stall_len;
    if (branch_taken) begin
      state_next     = RUN;
      stall_len_next = '0;
    end else if (stall) begin
      state_next = STALL;
      if (state == RUN)
        stall_len_next = LEN_W'(1);
      else if (stall_len != LEN_W'(MAX_STALL))
        stall_len_next = stall_len + LEN_W'(1);
    end else begin
      state_next     = RUN;
      stall_len_next = '0;
    end
  end

  assign timeout_hit = ~branch_taken & stall & (stall_len_next == LEN_W'(MAX_STALL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      stall_len     <= '0;
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pcplus4  <= '0;
      ifid_valid    <= 1'b0;
      idex_ctrl     <= '0;
      stall_timeout <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state     <= state_next;
      stall_len <= stall_len_next;
      if (mismatch)    protocol_err  <= 1'b1;
      if (timeout_hit) stall_timeout <= 1'b1;
      if (branch_taken) begin
        // Wrong-path fetch is dropped; a coincident stall request is ignored.
        pc           <= branch_target;
        ifid_instr   <= '0;
        ifid_pcplus4 <= '0;
        ifid_valid   <= 1'b0;
        idex_ctrl    <= '0;
      end else if (stall) begin
        idex_ctrl <= '0;
      end else begin
        pc           <= pc_plus4;
        ifid_instr   <= imem_instr;
        ifid_pcplus4 <= pc_plus4;
        ifid_valid   <= 1'b1;
        idex_ctrl    <= id_ctrl;
      end
    end
  end

`ifdef FETCH_STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (branch_taken) begin
      if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end else if (stall) begin
      if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed test-plan sequences then random traffic,
// every cycle compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stall_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          CTRL_W    = 16;
  localparam int          MAX_STALL = 4;
  localparam int          CNT_W     = 16;

  logic              clk = 1'b0;
  logic              reset, pcwrite, hazardflag, branch_taken;
  logic [31:0]       branch_target, imem_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       pc, ifid_instr, ifid_pcplus4;
  logic              ifid_valid, stall_timeout, protocol_err;
  logic [CTRL_W-1:0] idex_ctrl;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0]       m_pc, m_instr, m_p4;
  logic              m_valid, m_to, m_err;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_stalls, m_flushes, run_len;
  logic [31:0]       exp_q[$];

  fetch_stall_ctrl #(
    .RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .hazardflag(hazardflag),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pcplus4(ifid_pcplus4), .ifid_valid(ifid_valid),
    .idex_ctrl(idex_ctrl), .stall_timeout(stall_timeout), .protocol_err(protocol_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: what one clock edge does to the fetch stage, from the sampled inputs.
  task automatic model_edge();
    if (reset) begin
      m_pc = RESET_PC; m_instr = 0; m_p4 = 0; m_valid = 0; m_ctrl = 0;
      m_to = 0; m_err = 0; m_stalls = 0; m_flushes = 0; run_len = 0;
      exp_q.delete();
    end else begin
      if (pcwrite == hazardflag) m_err = 1;
      if (branch_taken) begin
        m_pc = branch_target; m_instr = 0; m_p4 = 0; m_valid = 0; m_ctrl = 0;
        run_len = 0;
        m_flushes = m_flushes + 1;
      end else if (!pcwrite || hazardflag) begin
        m_ctrl = 0;
        run_len = run_len + 1;
        if (run_len >= MAX_STALL) m_to = 1;
        m_stalls = m_stalls + 1;
      end else begin
        m_instr = imem_instr; m_p4 = m_pc + 4; m_valid = 1; m_ctrl = id_ctrl;
        m_pc = m_pc + 4;
        run_len = 0;
        exp_q.push_back(imem_instr);
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] issued;
    check("pc", pc, m_pc);
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pcplus4", ifid_pcplus4, m_p4);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    check("idex_ctrl", {16'b0, idex_ctrl}, {16'b0, m_ctrl});
    check("stall_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
    check("protocol_err", {31'b0, protocol_err}, {31'b0, m_err});
`ifdef FETCH_STALL_PERF_EN
    check("stall_cycles", {16'b0, stall_cycles}, m_stalls[31:0]);
    check("flush_count", {16'b0, flush_count}, m_flushes[31:0]);
`else
    check("stall_cycles", {16'b0, stall_cycles}, 32'd0);
    check("flush_count", {16'b0, flush_count}, 32'd0);
`endif
    // Each newly fetched instruction lands in IF/ID exactly once.
    if (exp_q.size() > 0) begin
      issued = exp_q.pop_front();
      check("issue_order", ifid_instr, issued);
    end
  endtask

  // Driver: apply inputs, take one edge, update model, compare away from the edge.
  task automatic drive(input logic rst, input logic pw, input logic hf,
                       input logic br, input logic [31:0] tgt);
    reset = rst; pcwrite = pw; hazardflag = hf; branch_taken = br; branch_target = tgt;
    imem_instr = $urandom; id_ctrl = CTRL_W'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1; pcwrite = 1; hazardflag = 0; branch_taken = 0;
    branch_target = 0; imem_instr = 0; id_ctrl = 0;

    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    // Normal flow: pc 0,4,8,C
    repeat (3) drive(0, 1, 0, 0, 0);
    check("tp_pc_c", pc, 32'hC);
    // One-cycle load-use stall, then resume
    drive(0, 0, 1, 0, 0);
    check("tp_bubble", {16'b0, idex_ctrl}, 32'd0);
    check("tp_pc_hold", pc, 32'hC);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Stall and flush together
    drive(0, 0, 1, 1, 32'h40);
    check("tp_flush_pc", pc, 32'h40);
    check("tp_flush_valid", {31'b0, ifid_valid}, 32'd0);
    drive(0, 1, 0, 0, 0);
    // Four-cycle stall trips the timeout, which stays after release
    repeat (3) drive(0, 0, 1, 0, 0);
    check("tp_to_before", {31'b0, stall_timeout}, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("tp_to_set", {31'b0, stall_timeout}, 32'd1);
    check("tp_to_pc", pc, 32'h44);
    repeat (2) drive(0, 1, 0, 0, 0);
    check("tp_to_sticky", {31'b0, stall_timeout}, 32'd1);
    // Protocol violations: 1/1 and 0/0 both hold the PC
    drive(0, 1, 1, 0, 0);
    check("tp_err_11", {31'b0, protocol_err}, 32'd1);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // PC wrap
    drive(0, 1, 0, 1, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0);
    check("tp_wrap", pc, 32'h0);
    // Reset during a stall
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    check("tp_rst_pc", pc, RESET_PC);
    check("tp_rst_err", {31'b0, protocol_err}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic rst, pw, hf, br;
      int   sel;
      rst = ($urandom_range(0, 59) == 0);
      br  = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 19);
      if (sel < 11)      begin pw = 1; hf = 0; end
      else if (sel < 18) begin pw = 0; hf = 1; end
      else if (sel == 18) begin pw = 1; hf = 1; end
      else               begin pw = 0; hf = 0; end
      drive(rst, pw, hf, br, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
